reg_file_mp: RTL

//  Parametrised multi-port register file: 1 write port, 2 registered read ports, per-register busy scoreboard.

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_rdport.sv | 27 ++
 rtl/reg_file_mp.sv | 55 +++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, depth helper and zero-register address for the register file
package reg_file_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int ZERO_ADDR = 0;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);
endpackage

// File: rtl/reg_file_rdport.sv
// reg_file_rdport: registered read mux with write-first data bypass and post-edge busy view
module reg_file_rdport import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int DEPTH = depth_of(ADDR_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
  input  logic [DEPTH-1:0]            i_busy_nxt,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic                        i_wr,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [DATA_W-1:0]           i_wr_data,
  output logic [DATA_W-1:0]           o_data,
  output logic                        o_busy
);
  // capture the addressed register, preferring same-cycle write data; busy comes from the next-state vector
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_data <= '0;
      o_busy <= 1'b0;
    end else begin
      o_data <= (i_wr && i_wr_addr == i_addr) ? i_wr_data : i_mem[i_addr];
      o_busy <= i_busy_nxt[i_addr];
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: 1W/2R register file with bypass, optional zero register and load-lock scoreboard
module reg_file_mp import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              lock_ok
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0] r_busy, w_busy_nxt;
  logic w_wr, w_lock_ok, w_lock_set;
  // a write-back in the same cycle frees the register, so the lock may take it; lock wins on busy
  always_comb begin
    w_wr = wr_en && !(ZERO_R0 != 0 && wr_addr == ZA);
    w_lock_ok = lock_en && (!r_busy[lock_addr] || (wr_en && wr_addr == lock_addr));
    w_lock_set = w_lock_ok && !(ZERO_R0 != 0 && lock_addr == ZA);
    w_busy_nxt = r_busy;
    if (w_wr) w_busy_nxt[wr_addr] = 1'b0;
    if (w_lock_set) w_busy_nxt[lock_addr] = 1'b1;
  end
  // storage, scoreboard and lock grant
  always_ff @(posedge clk or posedge CLB)
    if (CLB) begin
      r_mem <= '0;
      r_busy <= '0;
      lock_ok <= 1'b0;
    end else begin
      if (w_wr) r_mem[wr_addr] <= wr_data;
      r_busy <= w_busy_nxt;
      lock_ok <= w_lock_ok;
    end
  reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
    .clk(clk), .rst(CLB), .i_mem(r_mem), .i_busy_nxt(w_busy_nxt), .i_addr(rd_addr_a),
    .i_wr(w_wr), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_data(rd_data_a), .o_busy(rd_busy_a)
  );
  reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
    .clk(clk), .rst(CLB), .i_mem(r_mem), .i_busy_nxt(w_busy_nxt), .i_addr(rd_addr_b),
    .i_wr(w_wr), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_data(rd_data_b), .o_busy(rd_busy_b)
  );
endmodule
